// File: rtl/ans_pwm_out.sv
// PWM output stage for an error-feedback quantizer: one duty code per 2^W-cycle period,
// duty updates only on the period wrap, sticky underrun when no code arrives in time.
module ans_pwm_out #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    input  logic         clr_underrun,
    output logic         pwm_out,
    output logic         period_start,
    output logic         underrun,
    output logic [W-1:0] cnt_out
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [W-1:0] CntMax = {W{1'b1}};

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] duty_q, duty_d;
    logic         pwm_q, pwm_d;
    logic         ps_q, ps_d;
    logic         ur_q, ur_d;
    logic         ur_set;
    logic         ready_raw;
    logic         at_wrap;

    assign at_wrap = (cnt_q == CntMax);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        ur_set    = 1'b0;
        ready_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_raw = en;
                cnt_d     = '0;
                if (en && duty_valid) begin
                    state_d = StRun;
                    duty_d  = duty_in;
                end
            end
            StRun: begin
                cnt_d = cnt_q + W'(1);
                if (at_wrap) begin
                    // en is only sampled at the boundary, so a dropped-then-restored en is a no-op
                    if (en) begin
                        ready_raw = 1'b1;
                        if (duty_valid) begin
                            duty_d = duty_in;
                        end else begin
                            ur_set = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        ur_d = ur_set | (ur_q & ~clr_underrun);
        pwm_d = (state_d == StRun) && (cnt_d < duty_d);
        ps_d  = (state_d == StRun) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
            ur_q    <= ur_d;
        end
    end

    // Gate with rst_n so the handshake is silent while reset is held, even with en high.
    assign duty_ready   = rst_n & ready_raw;
    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign underrun     = ur_q;
    assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_ans_pwm_out.sv
// Randomized bench for ans_pwm_out (W=4): a period-position model predicts every output
// each cycle; directed phases cover reset, extremes, underrun, stop and mid-period reset.
module tb_ans_pwm_out;

    localparam int W = 4;
    localparam int Period = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] duty_in = '0;
    logic         duty_valid = 1'b0;
    logic         duty_ready;
    logic         clr_underrun = 1'b0;
    logic         pwm_out;
    logic         period_start;
    logic         underrun;
    logic [W-1:0] cnt_out;

    int n_checks = 0;
    int n_fail = 0;

    // Model: running flag, position inside the current period, duty governing it, sticky flag.
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_duty = 0;
    bit m_ur = 1'b0;

    ans_pwm_out #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .clr_underrun (clr_underrun),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .cnt_out      (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_duty = 0;
        m_ur = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs held across that edge.
    task automatic model_step();
        bit set_ur;
        set_ur = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (en && duty_valid) begin
                m_run = 1'b1;
                m_pos = 0;
                m_duty = int'(duty_in);
            end
        end else if (m_pos == Period - 1) begin
            if (en) begin
                if (duty_valid) m_duty = int'(duty_in);
                else set_ur = 1'b1;
                m_pos = 0;
            end else begin
                m_run = 1'b0;
                m_pos = 0;
            end
        end else begin
            m_pos = (m_pos + 1) % Period;
        end
        if (set_ur) m_ur = 1'b1;
        else if (clr_underrun) m_ur = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        bit exp_ready;
        exp_ready = rst_n && (m_run ? (m_pos == Period - 1 && en) : en);
        check({tag, ".pwm"}, pwm_out, m_run && (m_pos < m_duty));
        check({tag, ".ps"}, period_start, m_run && (m_pos == 0));
        check({tag, ".ready"}, duty_ready, exp_ready);
        check({tag, ".ur"}, underrun, m_ur);
        check({tag, ".cnt"}, cnt_out, m_run ? m_pos : 0);
    endtask

    task automatic step(input bit e, input bit v, input logic [W-1:0] d, input bit c,
                        input string tag);
        en = e;
        duty_valid = v;
        duty_in = d;
        clr_underrun = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs(tag);
    endtask

    // Duty code presented only matters at a transfer point; elsewhere feed junk.
    function automatic logic [W-1:0] pick(input int d);
        if (!m_run || m_pos == Period - 1) return W'(d);
        return W'($urandom);
    endfunction

    task automatic run_n(input int n, input bit e, input bit v, input int d, input bit c,
                         input string tag);
        for (int i = 0; i < n; i++) step(e, v, pick(d), c, tag);
    endtask

    task automatic run_to(input int pos, input int d, input string tag);
        bit reached;
        for (int i = 0; i < 3 * Period && !(m_run && m_pos == pos); i++)
            step(1'b1, 1'b1, pick(d), 1'b0, tag);
        reached = m_run && (m_pos == pos);
        check({tag, ".reach"}, reached, 1);
    endtask

    initial begin
        // Reset held with arbitrary inputs
        #1;
        check_outs("rst_async0");
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), W'($urandom), 1'($urandom), "rst_hold");
        rst_n = 1'b1;
        run_n(4, 1'b0, 1'b1, 9, 1'b0, "idle_en0");

        // Steady duty 5
        run_n(3 * Period + 1, 1'b1, 1'b1, 5, 1'b0, "steady5");

        // Duty 0 then 15 on consecutive periods
        run_to(Period - 1, 5, "to_ext");
        step(1'b1, 1'b1, 4'd0, 1'b0, "ext_d0");
        run_to(Period - 1, 0, "ext_p0");
        step(1'b1, 1'b1, 4'd15, 1'b0, "ext_d15");
        run_n(Period, 1'b1, 1'b1, 15, 1'b0, "ext_p15");

        // Underrun, hold, clear, clear coinciding with a new underrun
        run_to(Period - 1, 7, "ur_a");
        step(1'b1, 1'b1, 4'd7, 1'b0, "ur_load7");
        run_to(Period - 1, 7, "ur_b");
        step(1'b1, 1'b0, 4'd2, 1'b0, "ur_miss");
        run_n(5, 1'b1, 1'b1, 7, 1'b0, "ur_hold");
        step(1'b1, 1'b1, W'($urandom), 1'b1, "ur_clr");
        run_to(Period - 1, 7, "ur_c");
        step(1'b1, 1'b0, 4'd1, 1'b1, "ur_clr_set");
        run_n(4, 1'b1, 1'b1, 7, 1'b0, "ur_after");
        step(1'b1, 1'b1, W'($urandom), 1'b1, "ur_clr2");

        // Stop: duty 10, en dropped at cnt 3, glitch of en away from the wrap ignored
        run_to(Period - 1, 10, "stop_a");
        step(1'b1, 1'b1, 4'd10, 1'b0, "stop_load");
        run_to(3, 10, "stop_b");
        step(1'b0, 1'b1, 4'd10, 1'b0, "glitch");
        step(1'b1, 1'b1, 4'd10, 1'b0, "glitch");
        run_to(3, 10, "stop_c");
        run_n(2 * Period, 1'b0, 1'b1, 10, 1'b0, "stop");

        // Mid-period asynchronous reset
        step(1'b1, 1'b1, 4'd10, 1'b0, "mr_load");
        run_to(2, 10, "mr_to2");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outs("mr_async");
        step(1'b1, 1'b1, 4'd10, 1'b0, "mr_hold");
        rst_n = 1'b1;
        step(1'b1, 1'b1, 4'd3, 1'b0, "mr_load3");
        run_n(2 * Period, 1'b1, 1'b1, 3, 1'b0, "mr_p3");

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) != 0, ($urandom % 4) != 0, W'($urandom),
                 ($urandom % 8) == 0, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
